// File: rtl/calc_pkg.sv
// Shared definitions for the hex calculator input path: key codes, key
// classification helpers and the input-arbiter FSM state encoding.
package calc_pkg;

    localparam logic [4:0] KEY_PLUS  = 5'h10;
    localparam logic [4:0] KEY_MINUS = 5'h11;
    localparam logic [4:0] KEY_EQUAL = 5'h12;
    localparam logic [4:0] KEY_CLEAR = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_GAP
    } state_t;

    function automatic logic is_digit(input logic [4:0] key);
        return (key[4] == 1'b0);
    endfunction

    function automatic logic is_valid(input logic [4:0] key);
        return (key <= KEY_CLEAR);
    endfunction

    function automatic logic ends_expr(input logic [4:0] key);
        return (key == KEY_EQUAL) || (key == KEY_CLEAR);
    endfunction

endpackage

// File: rtl/calc_input_arbiter_if.sv
// Key-source handshakes plus the strobe/status bundle toward the calculator.
interface calc_input_arbiter_if;

    logic       req0;
    logic       req1;
    logic [4:0] key0;
    logic [4:0] key1;
    logic       ack0;
    logic       ack1;
    logic       valid_input;
    logic [4:0] input_value;
    logic       locked;
    logic       owner;
    logic       err;
    logic       tmo;

    modport master (
        output req0, req1, key0, key1,
        input  ack0, ack1, valid_input, input_value, locked, owner, err, tmo
    );

    modport slave (
        input  req0, req1, key0, key1,
        output ack0, ack1, valid_input, input_value, locked, owner, err, tmo
    );

endinterface

// File: rtl/calc_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last port granted
// while enabled, so a contested request goes to the other port next time.
module calc_rr_arb2 (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last;

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                last <= 1'b1;
        else if (en && (|req))    last <= grant[1];
    end

endmodule

// File: rtl/calc_input_arbiter.sv
// Shares the calculator key port between two sources: round-robin grant,
// expression locking until '=' or 'CL', idle gap after strobes, stall clear.
module calc_input_arbiter
    import calc_pkg::*;
#(
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 nrst,
    calc_input_arbiter_if.slave bus
);

    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT);

    state_t      state;
    logic [3:0]  gap_cnt;
    logic [15:0] tmo_cnt;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        sel;
    logic [4:0]  key_sel;
    logic        serve;

    assign req = {bus.req1, bus.req0};

    calc_rr_arb2 u_arb (
        .clk   (clk),
        .nrst  (nrst),
        .req   (req),
        .en    (state == ST_IDLE),
        .grant (grant)
    );

    // While locked only the owner may be served; otherwise the arbiter picks.
    always_comb begin
        sel     = (state == ST_LOCKED) ? bus.owner : grant[1];
        key_sel = sel ? bus.key1 : bus.key0;
        serve   = ((state == ST_IDLE) && (|req)) ||
                  ((state == ST_LOCKED) && req[bus.owner]);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= ST_IDLE;
            gap_cnt         <= '0;
            tmo_cnt         <= '0;
            bus.ack0        <= 1'b0;
            bus.ack1        <= 1'b0;
            bus.valid_input <= 1'b0;
            bus.input_value <= '0;
            bus.locked      <= 1'b0;
            bus.owner       <= 1'b0;
            bus.err         <= 1'b0;
            bus.tmo         <= 1'b0;
        end else begin
            bus.ack0        <= 1'b0;
            bus.ack1        <= 1'b0;
            bus.valid_input <= 1'b0;
            bus.err         <= 1'b0;
            bus.tmo         <= 1'b0;

            if (serve) begin
                bus.ack0 <= ~sel;
                bus.ack1 <= sel;
                state    <= ST_GAP;
                gap_cnt  <= '0;
                tmo_cnt  <= '0;
                if (is_valid(key_sel)) begin
                    bus.valid_input <= 1'b1;
                    bus.input_value <= key_sel;
                    if (ends_expr(key_sel)) begin
                        bus.locked <= 1'b0;
                    end else if (is_digit(key_sel) || key_sel == KEY_PLUS ||
                                 key_sel == KEY_MINUS) begin
                        bus.locked <= 1'b1;
                        bus.owner  <= sel;
                    end
                end else begin
                    bus.err <= 1'b1;
                end
            end else begin
                unique case (state)
                    ST_LOCKED: begin
                        // Owner stalled: force a clear so the calculator never hangs mid-expression.
                        if (tmo_cnt == TMO_LAST) begin
                            bus.valid_input <= 1'b1;
                            bus.input_value <= KEY_CLEAR;
                            bus.tmo         <= 1'b1;
                            bus.locked      <= 1'b0;
                            tmo_cnt         <= '0;
                            gap_cnt         <= '0;
                            state           <= ST_GAP;
                        end else begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= '0;
                            state   <= bus.locked ? ST_LOCKED : ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_input_arbiter.sv
// Directed bench for calc_input_arbiter with a small downstream calculator
// model that consumes the strobes.
module tb_calc_input_arbiter;
    import calc_pkg::*;

    localparam int GAP_C = 2;
    localparam int TMO_C = 8;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    calc_input_arbiter_if bus();

    calc_input_arbiter #(.GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int strobe_cyc[$];
    int back_to_back = 0;
    logic prev_valid = 1'b0;

    logic [15:0] acc    = '0;
    logic [15:0] cur    = '0;
    logic [15:0] result = 16'hFFFF;
    logic [4:0]  op     = KEY_PLUS;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] apply(input logic [15:0] a, input logic [4:0] o,
                                          input logic [15:0] b);
        return (o == KEY_MINUS) ? a - b : a + b;
    endfunction

    // Downstream calculator model plus strobe-spacing bookkeeping.
    always begin
        @(posedge clk);
        #1;
        if (bus.valid_input) begin
            strobe_cyc.push_back(cyc);
            if (prev_valid) back_to_back++;
            if (bus.input_value < 5'h10) begin
                cur = {cur[11:0], bus.input_value[3:0]};
            end else if (bus.input_value == KEY_PLUS || bus.input_value == KEY_MINUS) begin
                acc = apply(acc, op, cur);
                op  = bus.input_value;
                cur = '0;
            end else if (bus.input_value == KEY_EQUAL) begin
                result = apply(acc, op, cur);
                acc = '0;
                cur = '0;
                op  = KEY_PLUS;
            end else begin
                acc = '0;
                cur = '0;
                op  = KEY_PLUS;
            end
        end
        prev_valid = bus.valid_input;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [11:0] outs();
        return {bus.ack0, bus.ack1, bus.valid_input, bus.input_value,
                bus.locked, bus.owner, bus.err, bus.tmo};
    endfunction

    task automatic raise(input int p, input logic [4:0] k);
        if (p == 0) begin
            bus.req0 = 1'b1;
            bus.key0 = k;
        end else begin
            bus.req1 = 1'b1;
            bus.key1 = k;
        end
    endtask

    task automatic wait_ack(input int p, input logic [4:0] k, output int lat);
        logic a;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            a = (p == 0) ? bus.ack0 : bus.ack1;
            if (a) begin
                lat = i;
                break;
            end
        end
        if (lat > 0) begin
            check($sformatf("p%0d key %0h valid_input", p, k), bus.valid_input, is_valid(k));
            check($sformatf("p%0d key %0h err", p, k), bus.err, !is_valid(k));
            check($sformatf("p%0d key %0h other ack", p, k),
                  (p == 0) ? bus.ack1 : bus.ack0, 1'b0);
            if (is_valid(k))
                check($sformatf("p%0d key %0h input_value", p, k), bus.input_value, k);
        end
        if (p == 0) bus.req0 = 1'b0;
        else        bus.req1 = 1'b0;
    endtask

    task automatic send(input int p, input logic [4:0] k, output int lat);
        raise(p, k);
        wait_ack(p, k, lat);
    endtask

    task automatic apply_reset();
        nrst     = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick(2);
        check("reset outputs", outs(), '0);
        nrst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int n0;
        int bad_sp;
        int seen;
        logic [4:0] seq1 [10];
        seq1 = '{5'h01, 5'h00, 5'h00, KEY_PLUS, 5'h08, 5'h00, KEY_MINUS, 5'h06, 5'h00, KEY_EQUAL};
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.key0 = '0;
        bus.key1 = '0;

        apply_reset();

        // Single source expression 100+80-60=
        n0 = strobe_cyc.size();
        for (int i = 0; i < 10; i++) begin
            send(0, seq1[i], lat);
            check($sformatf("t1 latency key%0d", i), lat, (i == 0) ? 1 : GAP_C + 1);
            if (i == 0) check("t1 locked rises", {bus.locked, bus.owner}, 2'b10);
            if (i == 8) check("t1 locked held", bus.locked, 1'b1);
            if (i == 9) check("t1 locked falls", bus.locked, 1'b0);
        end
        tick(1);
        check("t1 strobe count", strobe_cyc.size() - n0, 10);
        bad_sp = 0;
        for (int i = n0 + 1; i < strobe_cyc.size(); i++)
            if (strobe_cyc[i] - strobe_cyc[i-1] != GAP_C + 1) bad_sp++;
        check("t1 strobe spacing", bad_sp, 0);
        check("t1 calculator result", result, 16'h0120);

        // Contention from IDLE after reset
        apply_reset();
        raise(1, 5'h07);
        send(0, 5'h05, lat);
        check("t2 p0 first latency", lat, 1);
        check("t2 p0 owns lock", {bus.locked, bus.owner}, 2'b10);
        send(0, KEY_EQUAL, lat);
        check("t2 p0 equal latency", lat, GAP_C + 1);
        wait_ack(1, 5'h07, lat);
        check("t2 p1 after close", lat, GAP_C + 1);
        check("t2 p1 owns lock", {bus.locked, bus.owner}, 2'b11);
        send(1, KEY_EQUAL, lat);
        check("t2 p1 equal latency", lat, GAP_C + 1);
        raise(0, KEY_CLEAR);
        raise(1, KEY_CLEAR);
        wait_ack(0, KEY_CLEAR, lat);
        check("t2 p0 wins second contest", lat, GAP_C + 1);
        wait_ack(1, KEY_CLEAR, lat);
        check("t2 p1 follows", lat, GAP_C + 1);
        check("t2 unlocked", bus.locked, 1'b0);

        // Non-owner held off while locked
        tick(2);
        send(0, 5'h05, lat);
        check("t3 p0 lock latency", lat, 1);
        raise(1, 5'h07);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (bus.ack1) seen++;
        end
        check("t3 no ack1 while locked", seen, 0);
        send(0, KEY_CLEAR, lat);
        check("t3 p0 clear latency", lat, 1);
        check("t3 unlocked by CL", bus.locked, 1'b0);
        wait_ack(1, 5'h07, lat);
        check("t3 p1 granted after gap", lat, GAP_C + 1);
        check("t3 p1 owns lock", {bus.locked, bus.owner}, 2'b11);
        send(1, KEY_EQUAL, lat);

        // Owner stall forces a clear
        tick(2);
        send(0, 5'h03, lat);
        check("t4 p0 lock latency", lat, 1);
        lat  = -1;
        seen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (bus.ack0) seen++;
            if (bus.valid_input) begin
                lat = i;
                break;
            end
        end
        check("t4 forced clear latency", lat, GAP_C + TMO_C + 1);
        check("t4 forced value", bus.input_value, KEY_CLEAR);
        check("t4 tmo and locked", {bus.tmo, bus.locked}, 2'b10);
        check("t4 no ack0", seen, 0);
        tick(1);
        check("t4 tmo single pulse", {bus.tmo, bus.valid_input}, 2'b00);

        // Owner request on the terminal-count cycle wins
        tick(1);
        send(0, 5'h03, lat);
        check("t4b lock latency", lat, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.tmo) seen++;
        end
        check("t4b no early timeout", seen, 0);
        send(0, 5'h04, lat);
        check("t4b req beats timeout", lat, 1);
        check("t4b no tmo, still locked", {bus.tmo, bus.locked}, 2'b01);
        send(0, KEY_EQUAL, lat);
        check("t4b closed", bus.locked, 1'b0);

        // Invalid keys
        tick(2);
        send(1, 5'h1A, lat);
        check("t5 p1 invalid latency", lat, 1);
        check("t5 unlocked unchanged", bus.locked, 1'b0);
        tick(2);
        send(0, 5'h02, lat);
        send(0, 5'h1F, lat);
        check("t5 locked invalid latency", lat, GAP_C + 1);
        check("t5 lock kept", {bus.locked, bus.owner}, 2'b10);
        send(0, KEY_EQUAL, lat);

        // Reset during GAP
        tick(2);
        send(0, 5'h09, lat);
        check("t6 digit latency", lat, 1);
        raise(0, 5'h04);
        #1;
        nrst = 1'b0;
        #1;
        check("t6 outputs cleared at reset", outs(), '0);
        tick(2);
        nrst = 1'b1;
        wait_ack(0, 5'h04, lat);
        check("t6 held req after release", lat, 1);
        check("t6 relocked", {bus.locked, bus.owner}, 2'b10);
        send(0, KEY_EQUAL, lat);

        tick(2);
        check("no back-to-back strobes", back_to_back, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_input_arbiter.md
# calc_input_arbiter

Shares the single key-input port of the four-function hex calculator between two key sources (e.g. front-panel keypad and a remote host). Each source hands over 5-bit key codes with a req/ack handshake. The arbiter grants round-robin and locks the calculator to one source for the length of an expression, i.e. until `=` or `CL`. It emits single-cycle `valid_input` / `input_value` strobes with a guaranteed idle gap, and clears the calculator automatically if a locked owner stalls.

## Interface
- `GAP`, default 2: idle cycles after every issued strobe; legal range 1..15.
- `TIMEOUT`, default 255: idle cycles of the lock owner before forced clear; legal range 1..65535.
- `clk`  in  1  clock, rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `req0` / `req1`  in  1  source request; held high with key stable until ack.
- `key0` / `key1`  in  5  key code: 0x00-0x0F digit, 0x10 `+`, 0x11 `-`, 0x12 `=`, 0x13 `CL`, 0x14-0x1F invalid.
- `ack0` / `ack1`  out  1  one-cycle pulse; key consumed.
- `valid_input`  out  1  one-cycle strobe to calculator.
- `input_value`  out  5  key code to calculator; valid when `valid_input` is high.
- `locked`  out  1  an expression is in progress.
- `owner`  out  1  lock holder; meaningful only while `locked` is high.
- `err`  out  1  one-cycle pulse; invalid key dropped.
- `tmo`  out  1  one-cycle pulse; forced clear issued.

## Operation
- All outputs are registered. Reset values:
  - all outputs 0.
  - state IDLE, gap counter 0, timeout counter 0.
  - round-robin pointer `last` = 1, so port 0 has first priority.
- FSM states: IDLE, LOCKED, GAP.
- IDLE:
  - If either `req` is high, grant that port.
  - If both are high, grant `!last`, then set `last` to the granted port.
  - Issue the granted key (see issue rules) and go to GAP.
  - If the key was a digit, `+` or `-`, set `locked` = 1 and `owner` = granted port. If it was `=` or `CL`, `locked` stays 0.
- LOCKED:
  - Only `req[owner]` is served; the other port waits with no ack.
  - `=` or `CL` from the owner is issued, clears `locked`, and goes to GAP.
  - Any other valid key is issued, keeps the lock, and goes to GAP.
- GAP:
  - Counts `GAP` cycles with no issue and no ack.
  - Then returns to LOCKED if `locked` is set, otherwise to IDLE.
- Issue rules:
  - A valid key pulses `ack` of the granted port together with `valid_input` in the same cycle; `input_value` = key.
  - An invalid key (0x14-0x1F) pulses `ack` and `err`. No `valid_input`, lock state unchanged, FSM still passes through GAP.
- Timeout:
  - In LOCKED, the counter increments every cycle `req[owner]` is low, and resets to 0 when it is high or on leaving LOCKED.
  - On reaching `TIMEOUT`, the arbiter issues `valid_input` = 1 with `input_value` = 0x13 (no ack), pulses `tmo`, clears `locked`, and goes to GAP.
- Simultaneous events:
  - Owner req and timeout terminal count in the same cycle: the req wins and the counter resets.
  - In IDLE, a request from the port that was `owner` before a timeout competes normally under round robin.
- Reset mid-operation: everything returns to reset values immediately. No strobe is emitted; a pending req is re-arbitrated after release.

## Timing
- Req is sampled at edge n. `ack` and `valid_input` are high during cycle n+1, for exactly one cycle.
- A source must drop or change `req`/`key` at the edge where it samples `ack` high. GAP ≥ 1 guarantees that key is never double-issued.
- Minimum spacing between strobes is GAP+1 cycles. A single source streaming keys gets one key per GAP+1 cycles.
- Forced clear: `valid_input` rises TIMEOUT+1 cycles after the last owner-idle cycle begins.
- Strobes never overlap; `valid_input` is never high in two consecutive cycles.

## Structure
- Shared package `calc_pkg` holds:
  - key constants `KEY_PLUS`=0x10, `KEY_MINUS`=0x11, `KEY_EQUAL`=0x12, `KEY_CLEAR`=0x13;
  - the `is_digit` / `is_valid` / `ends_expr` helper functions;
  - the FSM state enum.
- One sub-module is natural: `calc_rr_arb2`, a 2-way round-robin arbiter with `last` pointer, taking req[1:0] and an update enable and producing a one-hot grant.
- Timeout and gap counters stay inline.

## Test plan
- Port 0 sends 1,0,0,`+`,8,0,`-`,6,0,`=` (GAP=2):
  - ten strobes, each 3 cycles apart;
  - `locked` rises with 0x01 and falls with 0x12;
  - downstream calculator result = 0x0120.
- Both ports request from IDLE after reset:
  - port 0 is acked first;
  - after port 0's `=` closes its expression, port 1's pending key is issued;
  - in the next contested IDLE, port 0 wins again only after port 1 has been granted.
- Port 0 locked after key 0x05; port 1 holds req with 0x07:
  - no `ack1` while locked;
  - port 0 sends 0x13;
  - port 1 is granted GAP+1 cycles later.
- TIMEOUT=8, port 0 sends 0x03 then goes idle:
  - after 8 idle cycles, `valid_input` strobes with 0x13;
  - `tmo` pulses and `locked` drops;
  - no `ack0` is generated.
- Port 1 sends 0x1A:
  - `ack1` and `err` pulse;
  - `valid_input` stays 0 and lock state is unchanged.
- Assert `nrst` low during GAP after a digit issue:
  - all outputs 0 and `locked` = 0 immediately;
  - after release, a held `req0` is issued 1 cycle after the first sampling edge.
